// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory wait states, taken-branch flushes
// and load-use stalls into per-stage write enables, plus perf counters and a watchdog.
module pipeline_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int STALL_MAX    = 8,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_req,
   input  logic             branch_taken,
   input  logic             mem_busy,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             id_ex_we,
   output logic             ex_mem_we,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events,
   output logic             hazard_err
);

   // state    | meaning
   // S_RUN    | normal issue; stalls and branches resolved here
   // S_FLUSH  | squashing wrong-path instructions after a taken branch
   // S_MEM    | data memory busy, whole pipeline frozen
   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_FLUSH = 2'd1;
   localparam logic [1:0] S_MEM   = 2'd2;

   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [7:0] STALL_LIMIT  = 8'(STALL_MAX);
   localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

   logic [1:0]       state_q, state_d;
   logic [2:0]       flush_cnt_q, flush_cnt_d;
   logic             pend_q, pend_d;
   logic [7:0]       consec_q, consec_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_ev_q;
   logic             err_q;
   logic             stall_inc, flush_inc;

   always_comb begin
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      id_ex_we     = 1'b1;
      ex_mem_we    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      pend_d       = pend_q;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      case (state_q)
         S_RUN: begin
            if (mem_busy) begin
               {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
               state_d = S_MEM;
               pend_d  = branch_taken;
            end else if (branch_taken) begin
               // squashed instruction makes any concurrent stall_req moot
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               flush_inc    = 1'b1;
               if (MULTI_FLUSH) begin
                  state_d     = S_FLUSH;
                  flush_cnt_d = FLUSH_RELOAD;
               end
            end else if (stall_req) begin
               pc_we        = 1'b0;
               if_id_we     = 1'b0;
               id_ex_bubble = 1'b1;
               stall_inc    = 1'b1;
            end
         end
         S_FLUSH: begin
            if (mem_busy) begin
               {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
            end else begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               if (branch_taken) begin
                  flush_cnt_d = FLUSH_RELOAD;
                  flush_inc   = 1'b1;
               end else if (flush_cnt_q <= 3'd1) begin
                  flush_cnt_d = 3'd0;
                  state_d     = S_RUN;
               end else begin
                  flush_cnt_d = flush_cnt_q - 3'd1;
               end
            end
         end
         S_MEM: begin
            if (mem_busy) begin
               {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
            end else begin
               state_d = S_RUN;
               pend_d  = 1'b0;
               // a branch caught during the wait flushes in the release cycle
               if (pend_q) begin
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  flush_inc    = 1'b1;
                  if (MULTI_FLUSH) begin
                     state_d     = S_FLUSH;
                     flush_cnt_d = FLUSH_RELOAD;
                  end
               end
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      consec_d = 8'd0;
      if (stall_inc) consec_d = (consec_q == 8'hFF) ? consec_q : consec_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RUN;
         flush_cnt_q <= 3'd0;
         pend_q      <= 1'b0;
         consec_q    <= 8'd0;
         stall_cnt_q <= '0;
         flush_ev_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         pend_q      <= pend_d;
         consec_q    <= consec_d;
         if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (flush_inc && flush_ev_q != '1) flush_ev_q <= flush_ev_q + 1'b1;
         if (stall_inc && consec_d == STALL_LIMIT) err_q <= 1'b1;
      end
   end

   assign state_o      = state_q;
   assign stall_cycles = stall_cnt_q;
   assign flush_events = flush_ev_q;
   assign hazard_err   = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; stimulus pushes hand-computed
// expectations, a monitor compares them against the DUT once per cycle.
module tb_pipeline_hazard_ctrl;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst, stall_req, branch_taken, mem_busy;
   logic pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_bubble, hazard_err;
   logic [1:0] state_o;
   logic [CNT_W-1:0] stall_cycles, flush_events;

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .STALL_MAX(8), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stall_req(stall_req), .branch_taken(branch_taken),
      .mem_busy(mem_busy), .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
      .ex_mem_we(ex_mem_we), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
      .state_o(state_o), .stall_cycles(stall_cycles), .flush_events(flush_events),
      .hazard_err(hazard_err)
   );

   always #5 clk = ~clk;

   // {pc,ifid,idex,exmem, flush, bubble, state[1:0], stall[3:0], flushev[3:0], err}
   typedef struct {
      string       name;
      logic [16:0] exp;
   } item_t;

   item_t sb_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [16:0] mk(input logic [3:0] we, input logic fl, input logic bb,
                                      input logic [1:0] st, input logic [3:0] sc,
                                      input logic [3:0] fe, input logic err);
      return {we, fl, bb, st, sc, fe, err};
   endfunction

   task automatic cyc(input logic r, input logic s, input logic b, input logic m,
                      input string name, input logic chk, input logic [16:0] exp);
      item_t it;
      @(posedge clk);
      #1;
      rst = r; stall_req = s; branch_taken = b; mem_busy = m;
      if (chk) begin
         it.name = name;
         it.exp  = exp;
         sb_q.push_back(it);
      end
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         item_t it;
         logic [16:0] act;
         it  = sb_q.pop_front();
         act = {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_bubble,
                state_o, stall_cycles, flush_events, hazard_err};
         n_tests++;
         if (act !== it.exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", it.name, act, it.exp);
         end
      end
   end

   initial begin
      rst = 1'b1; stall_req = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
      cyc(1, 0, 0, 0, "rst0", 0, '0);
      cyc(1, 0, 0, 0, "rst1", 1, mk(4'hF, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, "idle", 1, mk(4'hF, 0, 0, 0, 0, 0, 0));
      // single load-use stall
      cyc(0, 1, 0, 0, "stall1",      1, mk(4'b0011, 0, 1, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, "stall1_after",1, mk(4'hF,    0, 0, 0, 1, 0, 0));
      // branch with simultaneous stall: stall squashed
      cyc(0, 1, 1, 0, "br_cyc0",     1, mk(4'hF, 1, 1, 0, 1, 0, 0));
      cyc(0, 0, 0, 0, "br_cyc1",     1, mk(4'hF, 1, 1, 1, 1, 1, 0));
      cyc(0, 0, 0, 0, "br_done",     1, mk(4'hF, 0, 0, 0, 1, 1, 0));
      // mem_busy with branch in first cycle; stall during wait not counted
      cyc(0, 0, 1, 1, "mw_a",        1, mk(4'h0, 0, 0, 0, 1, 1, 0));
      cyc(0, 1, 0, 1, "mw_b",        1, mk(4'h0, 0, 0, 2, 1, 1, 0));
      cyc(0, 0, 1, 1, "mw_c",        1, mk(4'h0, 0, 0, 2, 1, 1, 0));
      cyc(0, 0, 0, 1, "mw_d",        1, mk(4'h0, 0, 0, 2, 1, 1, 0));
      cyc(0, 0, 0, 0, "mw_release",  1, mk(4'hF, 1, 1, 2, 1, 1, 0));
      cyc(0, 0, 0, 0, "mw_flush",    1, mk(4'hF, 1, 1, 1, 1, 2, 0));
      cyc(0, 0, 0, 0, "mw_run",      1, mk(4'hF, 0, 0, 0, 1, 2, 0));
      // freeze inside FLUSH holds the flush count
      cyc(0, 0, 1, 0, "fz_br",       1, mk(4'hF, 1, 1, 0, 1, 2, 0));
      cyc(0, 0, 0, 1, "fz_freeze",   1, mk(4'h0, 0, 0, 1, 1, 3, 0));
      cyc(0, 0, 0, 0, "fz_flush",    1, mk(4'hF, 1, 1, 1, 1, 3, 0));
      cyc(0, 0, 0, 0, "fz_run",      1, mk(4'hF, 0, 0, 0, 1, 3, 0));
      // watchdog: 8 consecutive honoured stalls
      for (int i = 0; i < 8; i++)
         cyc(0, 1, 0, 0, "wd_stall", 1, mk(4'b0011, 0, 1, 0, 4'(1 + i), 3, 0));
      cyc(0, 0, 0, 0, "wd_err_set",  1, mk(4'hF, 0, 0, 0, 9, 3, 1));
      cyc(0, 0, 0, 0, "wd_sticky",   1, mk(4'hF, 0, 0, 0, 9, 3, 1));
      // stall counter saturation
      for (int i = 0; i < 7; i++)
         cyc(0, 1, 0, 0, "sat_stall", 1, mk(4'b0011, 0, 1, 0, 4'(9 + i), 3, 1));
      for (int i = 0; i < 3; i++)
         cyc(0, 1, 0, 0, "sat_hold",  1, mk(4'b0011, 0, 1, 0, 15, 3, 1));
      cyc(0, 0, 0, 0, "sat_idle",    1, mk(4'hF, 0, 0, 0, 15, 3, 1));
      // reset mid-FLUSH
      cyc(0, 0, 1, 0, "rf_br",       1, mk(4'hF, 1, 1, 0, 15, 3, 1));
      cyc(1, 0, 0, 0, "rf_rst",      1, mk(4'hF, 1, 1, 1, 15, 4, 1));
      cyc(0, 0, 0, 0, "rf_after",    1, mk(4'hF, 0, 0, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, "rf_idle",     1, mk(4'hF, 0, 0, 0, 0, 0, 0));
      begin
         int guard = 0;
         while (sb_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
         end
         if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", sb_q.size());
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
